counter_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit run counter between two requesters. Each requester asks for a timed run of `len` clock cycles. The block grants the counter to one requester at a time, sequences the run, and signals completion with a one-cycle pulse. It sits between client blocks and the counter datapath and owns the count register, so clients never drive the counter directly.

---
 rtl/counter_sched.sv | 143 ++++++++++++++
 tb/tb_counter_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sched.sv
// counter_sched: round-robin scheduler sharing one WIDTH-bit run counter
// between two requesters. Each granted request runs for len cycles, then
// pulses done for one cycle.
//
// Ports:
//   clk, rst (async, active-low)
//   req0_valid/req0_len/req0_ready : requester 0 handshake (ready is comb)
//   req1_valid/req1_len/req1_ready : requester 1 handshake (ready is comb)
//   abort                          : cancel the active run (RUN only)
//   busy, owner, counter           : registered run status
//   done, done_id                  : registered one-cycle completion pulse
//
// Build option: define COUNTER_SCHED_DOWN_EN for down-count mode
// (counter shows len-1..0 instead of 0..len-1; timing unchanged).
module counter_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_len,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_len,
    output logic             req1_ready,
    input  logic             abort,
    output logic             busy,
    output logic             owner,
    output logic [WIDTH-1:0] counter,
    output logic             done,
    output logic             done_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic             ptr;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             winner;
    logic [WIDTH-1:0] len_sel;
    logic             last;

    // A lone valid wins; on contention the priority pointer decides.
    assign grant0  = (state == IDLE) && req0_valid && (!req1_valid || !ptr);
    assign grant1  = (state == IDLE) && req1_valid && (!req0_valid || ptr);
    assign accept  = grant0 || grant1;
    assign winner  = grant1;
    assign len_sel = grant1 ? req1_len : req0_len;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

`ifdef COUNTER_SCHED_DOWN_EN
    // Down-count: the run ends on the cycle the counter shows zero.
    assign last = (counter == '0);
`else
    logic [WIDTH-1:0] terminal;

    // Up-count: the run ends on the cycle the counter shows len-1.
    assign last = (counter == terminal - WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            terminal <= '0;
        end else if (accept) begin
            terminal <= len_sel;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            busy    <= 1'b0;
            counter <= '0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        owner <= winner;
                        ptr   <= ~winner;
                        busy  <= 1'b1;
                        if (len_sel == '0) begin
                            // Zero-length run skips RUN entirely.
                            state   <= DONE;
                            counter <= '0;
                            done    <= 1'b1;
                            done_id <= winner;
                        end else begin
                            state <= RUN;
`ifdef COUNTER_SCHED_DOWN_EN
                            counter <= len_sel - WIDTH'(1);
`else
                            counter <= '0;
`endif
                        end
                    end
                end
                RUN: begin
                    // abort wins over the terminal condition.
                    if (abort) begin
                        state   <= IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                    end else if (last) begin
                        state   <= DONE;
                        counter <= '0;
                        done    <= 1'b1;
                        done_id <= owner;
                    end else begin
`ifdef COUNTER_SCHED_DOWN_EN
                        counter <= counter - WIDTH'(1);
`else
                        counter <= counter + WIDTH'(1);
`endif
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    counter <= '0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: scoreboard bench for counter_sched.
// Expected per-cycle status is queued at accept and drained as the run plays.
module tb_counter_sched;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [3:0] req0_len;
    logic       req0_ready;
    logic       req1_valid;
    logic [3:0] req1_len;
    logic       req1_ready;
    logic       abort;
    logic       busy;
    logic       owner;
    logic [3:0] counter;
    logic       done;
    logic       done_id;

    typedef struct packed {
        logic [3:0] cnt;
        logic       own;
        logic       bsy;
        logic       dn;
        logic       id;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   pass_cnt;
    int   total;
    int   cyc;

    counter_sched #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_len   (req0_len),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_len   (req1_len),
        .req1_ready (req1_ready),
        .abort      (abort),
        .busy       (busy),
        .owner      (owner),
        .counter    (counter),
        .done       (done),
        .done_id    (done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic drain;
        exp_t e;
        exp_t a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{cnt: counter, own: owner, bsy: busy, dn: done,
                  id: done & done_id};
            total++;
            if (a !== e) begin
                $display("FAIL run_status got=%h exp=%h t=%0t", a, e, $time);
            end else begin
                pass_cnt++;
            end
            if (exp_q.size() > 0) step();
        end
    endtask

    task automatic run_req(input logic id, input logic [3:0] len);
        int   w;
        logic rdy;
        logic other;
        if (id) begin
            req1_valid = 1'b1;
            req1_len   = len;
        end else begin
            req0_valid = 1'b1;
            req0_len   = len;
        end
        #1;
        w = 0;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && w < 20) begin
            step();
            w++;
            rdy = id ? req1_ready : req0_ready;
        end
        total++;
        if (!rdy) begin
            $display("FAIL accept_timeout id=%0d got=0 exp=1", id);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            return;
        end
        pass_cnt++;
        other = id ? req0_ready : req1_ready;
        total++;
        if (other !== 1'b0) begin
            $display("FAIL other_ready got=%b exp=0", other);
        end else begin
            pass_cnt++;
        end
        for (int i = 0; i < int'(len); i++) begin
`ifdef COUNTER_SCHED_DOWN_EN
            exp_q.push_back('{cnt: 4'(int'(len) - 1 - i), own: id,
                              bsy: 1'b1, dn: 1'b0, id: 1'b0});
`else
            exp_q.push_back('{cnt: 4'(i), own: id, bsy: 1'b1,
                              dn: 1'b0, id: 1'b0});
`endif
        end
        exp_q.push_back('{cnt: 4'd0, own: id, bsy: 1'b1, dn: 1'b1, id: id});
        exp_q.push_back('{cnt: 4'd0, own: id, bsy: 1'b0, dn: 1'b0, id: 1'b0});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rdy = id ? req1_ready : req0_ready;
        total++;
        if (rdy !== 1'b0) begin
            $display("FAIL ready_one_cycle got=%b exp=0", rdy);
        end else begin
            pass_cnt++;
        end
        drain();
    endtask

    task automatic test_reset;
        total++;
        if ({counter, owner, busy, done, done_id, req0_ready, req1_ready}
            !== 10'd0) begin
            $display("FAIL reset_outputs got=%b%b%b%b%b exp=0",
                     counter, owner, busy, done, done_id);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_single;
        run_req(1'b0, 4'd5);
    endtask

    task automatic test_contention;
        int base;
        int g;
        int offs[$];
        apply_reset();
        req0_len   = 4'd2;
        req1_len   = 4'd2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        grant_q = '{0, 1, 0};
        offs    = '{0, 4, 8};
        base    = -1;
        #1;
        for (int c = 0; c < 30 && grant_q.size() > 0; c++) begin
            if (req0_ready || req1_ready) begin
                g = grant_q.pop_front();
                if (base < 0) base = cyc;
                total++;
                if ({req1_ready, req0_ready} !== (g == 1 ? 2'b10 : 2'b01)) begin
                    $display("FAIL contention_grant got=%b%b exp_id=%0d",
                             req1_ready, req0_ready, g);
                end else begin
                    pass_cnt++;
                end
                total++;
                if (cyc - base !== offs.pop_front()) begin
                    $display("FAIL contention_time got=%0d", cyc - base);
                end else begin
                    pass_cnt++;
                end
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++;
        if (grant_q.size() != 0) begin
            $display("FAIL contention_timeout got=%0d exp=0", grant_q.size());
        end else begin
            pass_cnt++;
        end
        repeat (4) step();
        total++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL contention_idle got=%b%b exp=00", busy, done);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_zero_len;
        run_req(1'b1, 4'd0);
    endtask

    task automatic test_len4;
        run_req(1'b0, 4'd4);
    endtask

    task automatic test_abort;
        int n;
        int seen;
        req0_len   = 4'd10;
        req0_valid = 1'b1;
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin
            step();
            n++;
        end
        step();
        req0_valid = 1'b0;
        n = 0;
        while (counter != 4'd3 && n < 15) begin
            step();
            n++;
        end
        total++;
        if (counter !== 4'd3 || busy !== 1'b1) begin
            $display("FAIL abort_reach got=%0d exp=3", counter);
        end else begin
            pass_cnt++;
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if ({counter, busy, done} !== 6'd0) begin
            $display("FAIL abort_clear got=%0d/%b/%b exp=0/0/0",
                     counter, busy, done);
        end else begin
            pass_cnt++;
        end
        seen = 0;
        repeat (12) begin
            if (done || busy) seen++;
            step();
        end
        total++;
        if (seen !== 0) begin
            $display("FAIL abort_no_done got=%0d exp=0", seen);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_async_reset;
        int n;
        req1_len   = 4'd8;
        req1_valid = 1'b1;
        #1;
        n = 0;
        while (!req1_ready && n < 20) begin
            step();
            n++;
        end
        step();
        req1_valid = 1'b0;
        n = 0;
        while (counter != 4'd4 && n < 15) begin
            step();
            n++;
        end
        total++;
        if (counter !== 4'd4 || owner !== 1'b1) begin
            $display("FAIL arst_reach got=%0d/%b exp=4/1", counter, owner);
        end else begin
            pass_cnt++;
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({counter, owner, busy, done, done_id} !== 8'd0) begin
            $display("FAIL arst_clear got=%0d/%b/%b/%b/%b exp=0",
                     counter, owner, busy, done, done_id);
        end else begin
            pass_cnt++;
        end
        step();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            $display("FAIL arst_pointer got=%b%b exp=01",
                     req1_ready, req0_ready);
        end else begin
            pass_cnt++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
    endtask

    initial begin
        pass_cnt   = 0;
        total      = 0;
        rst        = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_len   = 4'd0;
        req1_len   = 4'd0;
        abort      = 1'b0;
        step();
        step();
        test_reset();
        rst = 1'b1;
        step();
        test_single();
        test_contention();
        test_zero_len();
        test_abort();
        test_len4();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
